// File: rtl/leglite_multi.sv
// leglite_multi: multicycle LEGLite core (FETCH/DECODE/EXEC/MEM/WB/HALT) with ready-handshaked memory ports.
// Defining LEGLITE_PERF_EN adds the cycle_cnt/instret performance counter outputs.
module leglite_multi #(
  parameter int                DWIDTH   = 16,
  parameter int                NREGS    = 8,
  parameter logic [DWIDTH-1:0] PC_RESET = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DWIDTH-1:0] iaddr,
  output logic              ireq,
  input  logic              iready,
  input  logic [15:0]       idata,
  output logic [DWIDTH-1:0] daddr,
  output logic              dread,
  output logic              dwrite,
  input  logic              dready,
  output logic [DWIDTH-1:0] dwdata,
  input  logic [DWIDTH-1:0] ddata,
  output logic [DWIDTH-1:0] alu_out,
  output logic              halted
`ifdef LEGLITE_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret
`endif
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LD   = 3'd5;
  localparam logic [2:0] OP_ST   = 3'd6;
  localparam logic [2:0] OP_CBZ  = 3'd7;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  localparam logic [DWIDTH-1:0] PC_ONE = DWIDTH'(1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [DWIDTH-1:0] pc;
  logic [15:0]       ir;
  logic [DWIDTH-1:0] alu_q;
  logic [DWIDTH-1:0] mdr;
  logic [DWIDTH-1:0] regs [8];

  logic signed [DWIDTH-1:0] a_p1, b_p1, imm_p1;

  logic [2:0] op, rm, rn, rd;
  logic [6:0] imm7;
  logic       is_alu, is_ld, is_st, is_cbz, use_imm, reg2loc;
  logic [1:0] alu_sel;
  logic signed [DWIDTH-1:0] alu_res;
  logic       zero;
  logic [DWIDTH-1:0] br_target;

  function automatic logic signed [DWIDTH-1:0] sext7(input logic [6:0] v);
    return {{(DWIDTH-7){v[6]}}, v};
  endfunction

  function automatic logic signed [DWIDTH-1:0] alu_fn(input logic [1:0] sel,
                                                       input logic signed [DWIDTH-1:0] a,
                                                       input logic signed [DWIDTH-1:0] b);
    case (sel)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return b;
    endcase
  endfunction

  // Indices beyond the implemented register count read as zero.
  function automatic logic [DWIDTH-1:0] rd_reg(input logic [2:0] idx);
    return (int'(idx) < NREGS) ? regs[idx] : '0;
  endfunction

  assign op   = ir[15:13];
  assign rm   = ir[12:10];
  assign imm7 = ir[12:6];
  assign rn   = ir[5:3];
  assign rd   = ir[2:0];

  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_cbz  = (op == OP_CBZ);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ADDI);
  assign use_imm = (op == OP_ADDI) || is_ld || is_st;
  assign reg2loc = is_st || is_cbz;

  always_comb begin
    alu_sel = ALU_ADD;
    case (op)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_CBZ:  alu_sel = ALU_PASS;
      default: alu_sel = ALU_ADD;
    endcase
  end

  assign alu_res   = alu_fn(alu_sel, a_p1, use_imm ? imm_p1 : b_p1);
  assign zero      = (alu_res == '0);
  assign br_target = pc + $unsigned(imm_p1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (iready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_cbz)             state_nxt = S_FETCH;
        else if (is_ld || is_st) state_nxt = S_MEM;
        else if (is_alu)        state_nxt = S_WB;
        else                    state_nxt = S_HALT;
      end
      S_MEM:    if (dready) state_nxt = is_ld ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_HALT;
    endcase
  end

  // Control, architectural state and visible output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= PC_RESET;
      iaddr  <= PC_RESET;
      ir     <= '0;
      alu_q  <= '0;
      dwdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (iready) begin
            ir <= idata;
            pc <= pc + PC_ONE;
          end
        end
        S_DECODE: dwdata <= rd_reg(rd);
        S_EXEC: begin
          alu_q <= alu_res;
          if (is_cbz) begin
            if (zero) begin
              pc    <= br_target;
              iaddr <= br_target;
            end else begin
              iaddr <= pc;
            end
          end
        end
        S_MEM: if (dready && is_st) iaddr <= pc;
        S_WB: begin
          if (int'(rd) < NREGS) regs[rd] <= is_ld ? mdr : alu_q;
          iaddr <= pc;
        end
        default: ;
      endcase
    end
  end

  // Operand and load-data latches carry no reset.
  always_ff @(posedge clock) begin
    if (state == S_DECODE) begin
      a_p1   <= rd_reg(rn);
      b_p1   <= rd_reg(reg2loc ? rd : rm);
      imm_p1 <= sext7(imm7);
    end
    if (state == S_MEM && dready && is_ld) mdr <= ddata;
  end

  assign ireq    = (state == S_FETCH) && !reset;
  assign dread   = (state == S_MEM) && is_ld && !reset;
  assign dwrite  = (state == S_MEM) && is_st && !reset;
  assign halted  = (state == S_HALT);
  assign daddr   = alu_q;
  assign alu_out = alu_q;

`ifdef LEGLITE_PERF_EN
  logic retire;
  assign retire = (state == S_WB) || (state == S_MEM && dready && is_st) ||
                  (state == S_EXEC && is_cbz);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else if (state != S_HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_leglite_multi.sv
// Bench for leglite_multi: directed programs plus random instruction streams with random wait states,
// checked against an instruction-level reference model (registers, PC, data memory, cycle counts).
module tb_leglite_multi;
  localparam int DW = 16;
  localparam int NR = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iready = 1'b0;
  logic          dready = 1'b0;
  logic [15:0]   idata = '0;
  logic [DW-1:0] ddata = '0;
  logic [DW-1:0] iaddr, daddr, dwdata, alu_out;
  logic          ireq, dread, dwrite, halted;
`ifdef LEGLITE_PERF_EN
  logic [31:0]   cycle_cnt, instret;
  int            m_instret = 0;
`endif

  leglite_multi #(.DWIDTH(DW), .NREGS(NR), .PC_RESET('0)) dut (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ireq(ireq), .iready(iready), .idata(idata),
    .daddr(daddr), .dread(dread), .dwrite(dwrite), .dready(dready),
    .dwdata(dwdata), .ddata(ddata), .alu_out(alu_out), .halted(halted)
`ifdef LEGLITE_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [15:0]   prog [64];
  logic [DW-1:0] dmem [64];
  logic [DW-1:0] m_reg [8];
  logic [DW-1:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rn, input logic [2:0] rm);
    return {op, rm, 4'b0000, rn, rd};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rn, input int imm);
    logic [6:0] f;
    f = 7'(imm);
    return {op, f, rn, rd};
  endfunction

  function automatic logic [DW-1:0] mr(input logic [2:0] idx);
    return (int'(idx) < NR) ? m_reg[idx] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_pc = '0;
`ifdef LEGLITE_PERF_EN
    m_instret = 0;
`endif
  endtask

  // Runs the instruction at the model PC through the DUT, called at a negedge while in FETCH.
  task automatic step(input int iwait, input int dwait);
    logic [15:0]   ins;
    logic [2:0]    op, rd, rn, rm;
    logic [DW-1:0] imm, a, brm, rdv, addr, res, pc1;
    int            cyc, exp_cyc, dcnt;
    bit            wr, chk_alu;
    chk("fetch_ireq", ireq, 1'b1);
    chk("fetch_addr", iaddr, m_pc);
    ins = prog[m_pc[5:0]];
    for (int i = 0; i < iwait; i++) begin
      iready = 1'b0;
      @(negedge clock);
      chk("ireq_hold", ireq, 1'b1);
      chk("iaddr_hold", iaddr, m_pc);
    end
    iready = 1'b1;
    idata  = ins;
    @(negedge clock);
    iready = 1'b0;
    idata  = 16'($urandom);

    op  = ins[15:13];
    rm  = ins[12:10];
    rn  = ins[5:3];
    rd  = ins[2:0];
    imm = {{(DW-7){ins[12]}}, ins[12:6]};
    a   = mr(rn);
    brm = mr(rm);
    rdv = mr(rd);
    pc1 = m_pc + 1'b1;
    addr = a + imm;
    res = '0; wr = 1'b0; chk_alu = 1'b1; exp_cyc = 4;
    case (op)
      3'd0: begin res = a + brm; wr = 1'b1; end
      3'd1: begin res = a - brm; wr = 1'b1; end
      3'd2: begin res = a & brm; wr = 1'b1; end
      3'd4: begin res = addr;    wr = 1'b1; end
      3'd5: begin res = dmem[addr[5:0]]; wr = 1'b1; exp_cyc = 5 + dwait; end
      3'd6: exp_cyc = 4 + dwait;
      default: begin exp_cyc = 3; chk_alu = 1'b0; end
    endcase

    cyc = iwait + 1;
    dcnt = 0;
    while (!(ireq || halted) && cyc < iwait + 30) begin
      chk("iaddr_stable", iaddr, m_pc);
      if (dread || dwrite) begin
        chk("dread", dread, op == 3'd5);
        chk("dwrite", dwrite, op == 3'd6);
        chk("daddr", daddr, addr);
        if (op == 3'd6) chk("dwdata", dwdata, rdv);
        dready = (dcnt == dwait);
        ddata  = dready ? dmem[addr[5:0]] : DW'($urandom);
        dcnt++;
      end
      @(negedge clock);
      cyc++;
      dready = 1'b0;
    end
    chk("cycles", cyc, iwait + exp_cyc);
    chk("halted", halted, op == 3'd3);
    if (chk_alu) chk("alu_out", alu_out, (op == 3'd5 || op == 3'd6) ? addr : res);

    if (wr && int'(rd) < NR) m_reg[rd] = res;
    if (op == 3'd6) dmem[addr[5:0]] = rdv;
    m_pc = (op == 3'd7 && rdv == '0) ? pc1 + imm : pc1;
`ifdef LEGLITE_PERF_EN
    if (op != 3'd3) m_instret++;
`endif
  endtask

  function automatic logic [15:0] rand_ins();
    int r;
    logic [2:0] op;
    r  = $urandom_range(0, 6);
    op = (r < 3) ? 3'(r) : 3'(r + 1);
    if (op <= 3'd2) return enc_r(op, 3'($urandom), 3'($urandom), 3'($urandom));
    return enc_i(op, 3'($urandom), 3'($urandom), $urandom_range(0, 127));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i] = DW'($urandom);
      prog[i] = '0;
    end
    model_reset();

    // Reset state
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_ireq", ireq, 1'b0);
    chk("rst_dread", dread, 1'b0);
    chk("rst_dwrite", dwrite, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_alu_out", alu_out, '0);
    chk("rst_daddr", daddr, '0);
    chk("rst_dwdata", dwdata, '0);
    chk("rst_iaddr", iaddr, '0);
`ifdef LEGLITE_PERF_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_instret", instret, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    // Directed program
    dmem[10] = 16'h1234;
    dmem[6]  = 16'hBEEF;
    prog[0]  = enc_r(3'd0, 3'd1, 3'd0, 3'd0);
    prog[1]  = enc_i(3'd4, 3'd1, 3'd1, 5);
    prog[2]  = enc_i(3'd5, 3'd2, 3'd0, 10);
    prog[3]  = enc_i(3'd6, 3'd2, 3'd1, 0);
    prog[4]  = enc_i(3'd5, 3'd3, 3'd1, 1);
    prog[5]  = enc_i(3'd6, 3'd3, 3'd0, 20);
    prog[6]  = enc_i(3'd4, 3'd4, 3'd0, -1);
    prog[7]  = enc_i(3'd4, 3'd4, 3'd4, 1);
    prog[8]  = enc_i(3'd7, 3'd4, 3'd0, -2);
    prog[9]  = enc_i(3'd4, 3'd7, 3'd0, 9);
    prog[10] = enc_i(3'd6, 3'd7, 3'd0, 21);
    prog[11] = enc_r(3'd0, 3'd5, 3'd1, 3'd7);
    prog[12] = enc_i(3'd6, 3'd5, 3'd0, 22);

    step(3, 0);
    step(0, 0);
    chk("x1_is_5", m_reg[1], 16'd5);
    step(0, 0);
    step(0, 2);
    chk("st_mem", dmem[5], 16'h1234);
    step(0, 1);
    step(0, 0);
    chk("ld_beef", dmem[20], 16'hBEEF);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    chk("cbz_taken_pc", m_pc, 16'd7);
    step(0, 0);
    step(0, 0);
    chk("cbz_fall_pc", m_pc, 16'd9);
    for (int i = 0; i < 4; i++) step(0, 0);

    // Random instruction stream with random wait states
    for (int i = 13; i < 64; i++) prog[i] = rand_ins();
    for (int i = 0; i < 120; i++)
      step(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 2));

    // Illegal opcode halts and stays halted
    prog[m_pc[5:0]] = enc_r(3'd3, 3'd1, 3'd2, 3'd3);
    step(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("halt_ireq", ireq, 1'b0);
      chk("halt_sticky", halted, 1'b1);
    end
`ifdef LEGLITE_PERF_EN
    chk("halt_instret", instret, 32'(m_instret));
`endif

    // Reset out of HALT, then reset again in the middle of a store
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    prog[0] = enc_i(3'd6, 3'd1, 3'd0, 3);
    prog[1] = enc_i(3'd4, 3'd1, 3'd1, 7);
    prog[2] = enc_i(3'd6, 3'd1, 3'd0, 0);
    @(negedge clock);
    iready = 1'b1;
    idata  = prog[0];
    @(negedge clock);
    iready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_dwrite", dwrite, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_dwrite", dwrite, 1'b0);
    chk("mid_rst_ireq", ireq, 1'b0);
    chk("mid_rst_iaddr", iaddr, '0);
`ifdef LEGLITE_PERF_EN
    chk("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("mid_rst_instret", instret, 32'd0);
`endif
    dready = 1'b1;
    iready = 1'b1;
    @(negedge clock);
    dready = 1'b0;
    iready = 1'b0;
    reset  = 1'b0;
    @(negedge clock);
    step(0, 0);
    step(0, 1);
    step(2, 0);
    chk("post_rst_mem", dmem[0], 16'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leglite_multi.md
Name: leglite_multi

Overview:
- Parametrised multicycle successor to the LEGLite single-cycle core.
- Executes the unchanged 16-bit LEGLite instruction set (opcode [15:13], Rm [12:10], imm7 [12:6], Rn [5:3], Rd [2:0]) through a state machine.
- Instruction and data ports carry ready handshakes, so slow or shared memories can insert wait states.
- Sits in the same place as the single-cycle core: between program memory and data memory in the top-level testbench/system.

Parameters:
- DWIDTH, 16: datapath, register and data-bus width; legal range 16..32. Instruction width is fixed at 16.
- NREGS, 8: register count; legal 2..8. Register indices >= NREGS read as 0 and writes to them are dropped.
- PC_RESET, 0: PC value loaded on reset; DWIDTH bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iaddr  out  DWIDTH  program memory address (PC).
- ireq  out  1  instruction fetch request.
- iready  in  1  idata valid this cycle; completes the fetch.
- idata  in  16  instruction word.
- daddr  out  DWIDTH  data memory address (ALU result register).
- dread  out  1  data read request.
- dwrite  out  1  data write request.
- dready  in  1  data access complete this cycle.
- dwdata  out  DWIDTH  store data (Rd register value latched in DECODE).
- ddata  in  DWIDTH  load data.
- alu_out  out  DWIDTH  registered ALU result, for debug.
- halted  out  1  core has stopped on an illegal opcode.

Behaviour:
- Reset (clock edge with reset=1):
  - PC=PC_RESET; state=FETCH.
  - ireq, dread, dwrite, halted = 0.
  - alu_out = 0, daddr = 0, dwdata = 0, IR = 0.
  - The register file is cleared to 0.
  - Reset overrides any in-flight access. Requests drop the same edge, and a late iready/dready is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - ireq=1 and iaddr=PC, both held stable until iready=1.
  - On the iready edge: IR<=idata, PC<=PC+1, go to DECODE.
  - iready=0 keeps the core in FETCH indefinitely, with no timeout.
- DECODE: latch A=R[Rn] and B=R[Rm or Rd per reg2loc]; sign-extend imm7 to DWIDTH; go to EXEC.
- EXEC:
  - The ALU computes using the existing ALU select encoding, widened to DWIDTH. Results wrap modulo 2^DWIDTH.
  - The result is registered into alu_out/daddr.
  - ALU ops go to WB. LD/ST go to MEM.
  - CBZ: if the zero flag is set, PC<=PC+sext(imm7); otherwise PC is unchanged. Then go to FETCH.
  - The branch offset is relative to the incremented PC, as in the single-cycle core.
  - Illegal/unused opcode goes to HALT.
- MEM:
  - dread=1 (LD) or dwrite=1 (ST), held with daddr/dwdata stable until dready=1.
  - dread and dwrite are never both 1.
  - On dready: LD latches ddata and goes to WB; ST goes to FETCH.
- WB: R[Rd] <= ALU result or load data (memtoreg); go to FETCH. Exactly one register write per instruction.
- HALT: halted=1, all requests 0, state is sticky until reset.
- CPI: ALU ops 4 cycles, CBZ 3, ST 4, LD 5, each with zero wait states. Every wait cycle adds 1.
- Register reads in DECODE see WB writes from the previous instruction. No forwarding is needed because execution is strictly sequential.
- PC wraps modulo 2^DWIDTH.

Optional Feature:
- Macro: LEGLITE_PERF_EN.
- When defined:
  - Adds output ports cycle_cnt (32) and instret (32), both reset to 0.
  - cycle_cnt increments every non-reset cycle while not halted.
  - instret increments once on the final-state edge of each completed instruction (WB, ST MEM completion, CBZ EXEC).
  - Both counters wrap at 2^32 and freeze in HALT.
- When undefined: the ports and logic are absent, and core behaviour is identical.

Test Plan:
- Reset then program {ADD X1,X0,X0 ; ADDI X1,X1,#5}, iready tied 1. Required: X1=5 after 8 cycles; iaddr sequence 0,0,0,0,1,...; halted=0.
- Wait states: iready low for 3 cycles on the first fetch. Required: ireq and iaddr stay stable, FETCH is held, and the first instruction retires 3 cycles late.
- ST X2,[X1,#0] with X2=0x1234, X1=5, dready delayed 2 cycles. Required: dwrite=1 for 3 cycles with daddr=5 and dwdata=0x1234 stable; then FETCH.
- LD X3,[X1,#0] with ddata=0xBEEF. Required: X3=0xBEEF after WB; LD takes 5 cycles.
- CBZ taken (Rd=0, imm=-2) loops PC back; not-taken falls through. DWIDTH=32 build: 0xFFFFFFFF+1 = 0 with zero flag set.
- Illegal opcode: halted=1 with no further ireq. Reset asserted mid-MEM returns to FETCH at PC_RESET; with LEGLITE_PERF_EN, both counters read 0.
